pad_cell_input_filter: RTL and testbench

//  Simulation-target input pad cell: the receive-side counterpart of the output pad cell.

---
 rtl/pad_cell_input_filter.sv | 92 +++++++++
 tb/tb_pad_cell_input_filter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pad_cell_input_filter.sv
// Receive-side pad cell: samples the pad, synchronizes, glitch-filters the level
// and reports one-cycle rise/fall pulses. The pad wire is never driven.
package core_v_mcu_pkg;
    typedef enum logic [1:0] {TOP, BOTTOM, LEFT, RIGHT} pad_side_e;
endpackage

module pad_cell_input_filter #(
    parameter int unsigned               PADATTR       = 16,
    parameter core_v_mcu_pkg::pad_side_e SIDE          = core_v_mcu_pkg::TOP,
    parameter int unsigned               SYNC_STAGES   = 2,
    parameter int unsigned               FILTER_CYCLES = 4,
    parameter int unsigned               PADATTR_RND   = (PADATTR == 0) ? 1 : PADATTR
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    inout  wire                    pad_io,
    input  logic [PADATTR_RND-1:0] pad_attributes_i,
    output logic                   pad_in_o,
    output logic                   pad_rise_o,
    output logic                   pad_fall_o
);

    localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam bit SIDE_UNUSED = (SIDE == core_v_mcu_pkg::TOP);

    if (SYNC_STAGES < 2) begin : g_err_sync
        $error("pad_cell_input_filter: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_err_filter
        $error("pad_cell_input_filter: FILTER_CYCLES must be >= 1");
    end

    // Zero-extend so the bypass/invert bits exist even for a 1-bit attribute port.
    logic [PADATTR_RND+1:0] attr_ext;
    logic                   bypass;
    logic                   invert;
    logic                   unused_attr;

    assign attr_ext    = {2'b00, pad_attributes_i};
    assign bypass      = attr_ext[0];
    assign invert      = attr_ext[1];
    assign unused_attr = ^attr_ext[PADATTR_RND+1:2];

    assign pad_io = 1'bz;

    logic raw;
    assign raw = (pad_io === 1'b1) ^ invert;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   q_prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d  = '0;
        q_d    = q_q;
        if (bypass) begin
            q_d = s;
        end else if (s != q_q) begin
            // A mismatch must persist FILTER_CYCLES consecutive edges to be accepted.
            if (cnt_q == CNT_LAST) begin
                q_d = s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            q_q      <= 1'b0;
            q_prev_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            q_prev_q <= q_q;
        end
    end

    assign pad_in_o   = q_q;
    assign pad_rise_o = q_q & ~q_prev_q;
    assign pad_fall_o = ~q_q & q_prev_q;

endmodule

// File: tb/tb_pad_cell_input_filter.sv
// Bench for pad_cell_input_filter: default instance plus a SYNC_STAGES=3/FILTER_CYCLES=1
// instance, checked by vector table, hand sequences and a random run against a reference model.
module tb_pad_cell_input_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pad_en;
    logic        pad_val;
    logic [15:0] attr;
    wire         pad_w;
    logic        in1, r1, f1, in2, r2, f2;

    int checks = 0;
    int errors = 0;

    assign pad_w = pad_en ? pad_val : 1'bz;

    always #5 clk = ~clk;

    pad_cell_input_filter u_dut1 (
        .clk_i            (clk),
        .rst_i            (rst),
        .pad_io           (pad_w),
        .pad_attributes_i (attr),
        .pad_in_o         (in1),
        .pad_rise_o       (r1),
        .pad_fall_o       (f1)
    );

    pad_cell_input_filter #(.SYNC_STAGES(3), .FILTER_CYCLES(1)) u_dut2 (
        .clk_i            (clk),
        .rst_i            (rst),
        .pad_io           (pad_w),
        .pad_attributes_i (attr),
        .pad_in_o         (in2),
        .pad_rise_o       (r2),
        .pad_fall_o       (f2)
    );

    // Reference model: delay line of raw samples plus a mismatch streak counter.
    typedef struct {
        bit [7:0] sh;
        int       streak;
        bit       q;
        bit       qp;
    } mstate_t;

    mstate_t m1, m2;

    function automatic void mreset(inout mstate_t m);
        m.sh = '0; m.streak = 0; m.q = 1'b0; m.qp = 1'b0;
    endfunction

    function automatic void mstep(inout mstate_t m, input int S, input int F,
                                  input bit r, input bit rawv, input bit byp);
        bit s;
        if (r) begin
            mreset(m);
            return;
        end
        s    = m.sh[S-1];
        m.qp = m.q;
        if (byp) begin
            m.q = s; m.streak = 0;
        end else if (s == m.q) begin
            m.streak = 0;
        end else begin
            m.streak++;
            if (m.streak >= F) begin
                m.q = s; m.streak = 0;
            end
        end
        m.sh = {m.sh[6:0], rawv};
    endfunction

    function automatic logic [2:0] eo(input mstate_t m);
        return {m.q, m.q & ~m.qp, ~m.q & m.qp};
    endfunction

    function automatic bit raw_now();
        return (pad_en & pad_val) ^ attr[1];
    endfunction

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {in,rise,fall}=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        bit rv;
        @(posedge clk);
        rv = raw_now();
        mstep(m1, 2, 4, rst, rv, attr[0]);
        mstep(m2, 3, 1, rst, rv, attr[0]);
        @(negedge clk);
        chk("dut1_model", {in1, r1, f1}, eo(m1));
        chk("dut2_model", {in2, r2, f2}, eo(m2));
    endtask

    task automatic async_reset(input string nm);
        #3 rst = 1'b1;
        #1;
        mreset(m1);
        mreset(m2);
        chk({nm, "_dut1"}, {in1, r1, f1}, 3'b000);
        chk({nm, "_dut2"}, {in2, r2, f2}, 3'b000);
    endtask

    // Hand-computed latency sequence: level v appears at edge e1 (dut1) / e2 (dut2).
    task automatic lat_seq(input string nm, input int nedges, input int e1, input int e2, input bit v);
        bit x1, x2;
        for (int e = 0; e < nedges; e++) begin
            tick();
            x1 = (e >= e1) ? v : ~v;
            x2 = (e >= e2) ? v : ~v;
            chk($sformatf("%s_d1_e%0d", nm, e), {in1, r1, f1}, {x1, v && e == e1, !v && e == e1});
            chk($sformatf("%s_d2_e%0d", nm, e), {in2, r2, f2}, {x2, v && e == e2, !v && e == e2});
        end
    endtask

    typedef struct {
        bit       pv;
        bit [1:0] at;
        bit [2:0] exp;
    } vec_t;

    vec_t tbl[38];

    initial begin
        for (int i = 0;  i < 38; i++) tbl[i] = '{1'b1, 2'b00, 3'b000};
        tbl[5]  = '{1'b1, 2'b00, 3'b110};
        tbl[6]  = '{1'b1, 2'b00, 3'b100};
        for (int i = 7;  i < 10; i++) tbl[i] = '{1'b0, 2'b00, 3'b100};
        for (int i = 10; i < 17; i++) tbl[i] = '{1'b1, 2'b00, 3'b100};
        for (int i = 17; i < 22; i++) tbl[i] = '{1'b0, 2'b00, 3'b100};
        tbl[22] = '{1'b0, 2'b00, 3'b001};
        tbl[23] = '{1'b0, 2'b00, 3'b000};
        for (int i = 24; i < 27; i++) tbl[i] = '{1'b1, 2'b00, 3'b000};
        for (int i = 27; i < 34; i++) tbl[i] = '{1'b0, 2'b00, 3'b000};
        tbl[34] = '{1'b1, 2'b01, 3'b000};
        tbl[35] = '{1'b1, 2'b01, 3'b000};
        tbl[36] = '{1'b1, 2'b01, 3'b110};
        tbl[37] = '{1'b1, 2'b01, 3'b100};

        mreset(m1);
        mreset(m2);

        // Reset with pad high, then release: dut1 rises at edge 5, dut2 at edge 3.
        rst = 1'b1; pad_en = 1'b1; pad_val = 1'b1; attr = '0;
        repeat (3) tick();
        chk("reset_dut1", {in1, r1, f1}, 3'b000);
        chk("reset_dut2", {in2, r2, f2}, 3'b000);
        rst = 1'b0;
        lat_seq("t1", 7, 5, 3, 1'b1);

        // Vector table: latency, fall, glitches in both directions, bypass latency.
        rst = 1'b1; pad_val = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 38; i++) begin
            pad_en  = 1'b1;
            pad_val = tbl[i].pv;
            attr    = {14'b0, tbl[i].at};
            tick();
            chk($sformatf("vec%0d", i), {in1, r1, f1}, tbl[i].exp);
        end

        // Floating pad with invert reads as 1; driving it high then gives a fall.
        rst = 1'b1; pad_en = 1'b0; pad_val = 1'b0; attr = 16'h0002;
        repeat (2) tick();
        rst = 1'b0;
        lat_seq("t4_z_inv", 7, 5, 3, 1'b1);
        pad_en = 1'b1; pad_val = 1'b1;
        lat_seq("t4_fall", 7, 5, 3, 1'b0);

        // Async reset between edges 3 and 4 discards the count; full latency afterwards.
        rst = 1'b1; pad_en = 1'b1; pad_val = 1'b0; attr = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        pad_val = 1'b1;
        repeat (4) tick();
        async_reset("t5_async");
        tick();
        rst = 1'b0;
        lat_seq("t5", 7, 5, 3, 1'b1);

        // Alternating pad every cycle: dut2 follows each level, pulses alternate.
        for (int i = 0; i < 12; i++) begin
            pad_val = ~pad_val;
            tick();
            chk($sformatf("t6_excl%0d", i), {1'b0, r2 & f2, r1 & f1}, 3'b000);
        end

        // Random run against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) pad_val = ~pad_val;
            pad_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) attr[0] = ~attr[0];
            if ($urandom_range(0, 29) == 0) attr[1] = ~attr[1];
            if ($urandom_range(0, 9) == 0) attr[15:2] = 14'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rand_async");
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
